// File: rtl/debug_pkg.sv
// Shared constants for the debug clock controller: FSM state encoding,
// command opcodes and the divider value loaded at reset.
package debug_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_HALTED = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_STOP    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_STEP    = 2'b10;
    localparam logic [1:0] OP_SET_DIV = 2'b11;

    // Divider value after reset: one tick per cycle
    localparam int unsigned DIV_RESET = 1;

endpackage

// File: rtl/debug_clk_ctrl_if.sv
// Command and status bundle of the debug clock controller.
// master: the debugger side issuing commands; slave: the controller.
interface debug_clk_ctrl_if #(
    parameter int COUNTER_BITS = 32,
    parameter int STEP_BITS    = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [COUNTER_BITS-1:0] cmd_arg;
    logic                    halt_req;
    logic                    tick;
    logic                    running;
    logic                    halted;
    logic                    step_done;
    logic [COUNTER_BITS-1:0] divider_q;
    logic [STEP_BITS-1:0]    steps_left;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, halt_req,
        input  cmd_ready, tick, running, halted, step_done, divider_q, steps_left
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, halt_req,
        output cmd_ready, tick, running, halted, step_done, divider_q, steps_left
    );
endinterface

// File: rtl/debug_tick_gen.sv
// Divider counter: counts 0..div_eff-1 while enabled and flags the last
// count with wrap. Held at 0 whenever disabled or cleared.
module debug_tick_gen #(
    parameter int COUNTER_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [COUNTER_BITS-1:0] div_eff,
    output logic                    wrap
);

    logic [COUNTER_BITS-1:0] cnt_q;
    logic [COUNTER_BITS-1:0] cnt_d;

    assign wrap = enable && (cnt_q == div_eff - COUNTER_BITS'(1));

    // Next count: restart on clear/disable or at the end of the period
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = '0;
        if (enable && !clear && !wrap) begin
            cnt_d = cnt_q + COUNTER_BITS'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: async reset goes in the sensitivity list; state uses <= so all registers update together.
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_clk_ctrl.sv
// Debug clock controller: gates a core-clock enable (tick) under debugger
// control with STOP / RUN / STEP n / SET_DIV commands and a halt request.
module debug_clk_ctrl #(
    parameter int COUNTER_BITS = 32,
    parameter int STEP_BITS    = 16
) (
    input logic             clk,
    input logic             reset_n,
    debug_clk_ctrl_if.slave bus
);
    import debug_pkg::*;

    logic [1:0]              state_q, state_d;
    logic                    tick_q, tick_d;
    logic                    step_done_q, step_done_d;
    logic [STEP_BITS-1:0]    steps_left_q, steps_left_d;
    logic [COUNTER_BITS-1:0] div_q, div_d;

    logic [COUNTER_BITS-1:0] div_eff;
    logic [STEP_BITS-1:0]    step_arg;
    logic                    active;
    logic                    accept;
    logic                    restart;
    logic                    cnt_clear;
    logic                    wrap;

    assign div_eff   = (div_q == '0) ? COUNTER_BITS'(1) : div_q;
    assign step_arg  = bus.cmd_arg[STEP_BITS-1:0];
    assign active    = (state_q != ST_HALTED);
    assign accept    = bus.cmd_valid && bus.cmd_ready;
    // Counter restarts on any command that restarts the period and whenever we end up halted
    assign cnt_clear = restart || (state_d == ST_HALTED);

    debug_tick_gen #(
        .COUNTER_BITS(COUNTER_BITS)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (active),
        .clear   (cnt_clear),
        .div_eff (div_eff),
        .wrap    (wrap)
    );

    // Next-state: halt_req wins, then natural ticks, then accepted commands
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        div_d        = div_q;
        tick_d       = 1'b0;
        step_done_d  = 1'b0;
        restart      = 1'b0;

        if (active && bus.halt_req) begin
            // Any command accepted on this edge is consumed without effect
            state_d = ST_HALTED;
        end else begin
            if (wrap) begin
                tick_d = 1'b1;
                if (state_q == ST_STEP) begin
                    steps_left_d = steps_left_q - STEP_BITS'(1);
                    if (steps_left_q == STEP_BITS'(1)) begin
                        state_d     = ST_HALTED;
                        step_done_d = 1'b1;
                    end
                end
            end

            // Commands are only accepted in HALTED or RUN, never alongside a STEP tick
            if (accept) begin
                case (bus.cmd_op)
                    OP_STOP: begin
                        state_d = ST_HALTED;
                        tick_d  = 1'b0;
                    end
                    OP_RUN: begin
                        if (state_q == ST_HALTED) begin
                            state_d = ST_RUN;
                            restart = 1'b1;
                        end
                    end
                    OP_STEP: begin
                        tick_d  = 1'b0;
                        restart = 1'b1;
                        if (step_arg != '0) begin
                            state_d      = ST_STEP;
                            steps_left_d = step_arg;
                        end else begin
                            state_d     = ST_HALTED;
                            step_done_d = 1'b1;
                        end
                    end
                    OP_SET_DIV: begin
                        div_d = bus.cmd_arg;
                        if (state_q == ST_RUN) begin
                            tick_d  = 1'b0;
                            restart = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HALTED;
            tick_q       <= 1'b0;
            step_done_q  <= 1'b0;
            steps_left_q <= '0;
            div_q        <= COUNTER_BITS'(DIV_RESET);
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            step_done_q  <= step_done_d;
            steps_left_q <= steps_left_d;
            div_q        <= div_d;
        end
    end

    assign bus.cmd_ready  = (state_q != ST_STEP);
    assign bus.tick       = tick_q;
    assign bus.running    = active;
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.step_done  = step_done_q;
    assign bus.divider_q  = div_q;
    assign bus.steps_left = steps_left_q;

endmodule

// File: tb/tb_debug_clk_ctrl.sv
// Self-checking bench for debug_clk_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_debug_clk_ctrl;
    import debug_pkg::*;

    localparam int CB = 32;
    localparam int SB = 16;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    debug_clk_ctrl_if #(.COUNTER_BITS(CB), .STEP_BITS(SB)) bus ();

    debug_clk_ctrl #(.COUNTER_BITS(CB), .STEP_BITS(SB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] arg;
        logic        h;
        logic        tick;
        logic        done;
        logic        halted;
        logic        ready;
        logic [15:0] steps;
        logic [31:0] div;
    } vec_t;

    vec_t vecs[14];

    // Behavioural model: mode 0 halted, 1 run, 2 step; m_wait = edges until next tick
    int          m_mode;
    logic [31:0] m_div;
    int          m_left;
    int          m_wait;
    logic        m_tick;
    logic        m_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_of(input logic [31:0] d);
        return (d == 32'd0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_div = 32'd1; m_left = 0; m_wait = 0; m_tick = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] op, input logic [31:0] arg, input logic h);
        logic acc;
        logic tick_now;
        int   n;
        m_tick = 1'b0;
        m_done = 1'b0;
        acc    = v && (m_mode != 2);
        n      = int'(arg[15:0]);
        if (m_mode != 0 && h) begin
            m_mode = 0;
        end else begin
            tick_now = (m_mode != 0) && (m_wait == 1);
            if (m_mode != 0) m_wait = tick_now ? eff_of(m_div) : m_wait - 1;
            if (tick_now) begin
                m_tick = 1'b1;
                if (m_mode == 2) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_done = 1'b1; end
                end
            end
            if (acc) begin
                case (op)
                    OP_STOP: begin m_mode = 0; m_tick = 1'b0; end
                    OP_RUN: if (m_mode == 0) begin m_mode = 1; m_wait = eff_of(m_div); end
                    OP_STEP: begin
                        m_tick = 1'b0;
                        if (n != 0) begin m_mode = 2; m_left = n; m_wait = eff_of(m_div); end
                        else begin m_mode = 0; m_done = 1'b1; end
                    end
                    default: begin
                        m_div = arg;
                        if (m_mode == 1) begin m_tick = 1'b0; m_wait = eff_of(m_div); end
                    end
                endcase
            end
        end
    endtask

    // Apply inputs, then let one rising edge pass and settle
    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] arg, input logic h);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.halt_req  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_STOP, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_STOP;
        bus.cmd_arg   = '0;
        bus.halt_req  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tick"},       bus.tick,       1'b0);
        check({tag, "_running"},    bus.running,    1'b0);
        check({tag, "_halted"},     bus.halted,     1'b1);
        check({tag, "_step_done"},  bus.step_done,  1'b0);
        check({tag, "_steps_left"}, bus.steps_left, 16'd0);
        check({tag, "_divider"},    bus.divider_q,  32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ticks;
        logic seen;

        // inputs                                    tick  done  halt  rdy   steps  div
        vecs[0]  = '{1'b1, OP_SET_DIV, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[1]  = '{1'b1, OP_STEP,    32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'd0};
        vecs[2]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'd0};
        vecs[3]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'd0};
        vecs[4]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[5]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[6]  = '{1'b1, OP_STEP,    32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[7]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[8]  = '{1'b1, OP_RUN,     32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0};
        vecs[9]  = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0};
        vecs[10] = '{1'b1, OP_STOP,    32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[11] = '{1'b0, OP_STOP,    32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};
        vecs[12] = '{1'b1, OP_RUN,     32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0};
        vecs[13] = '{1'b0, OP_STOP,    32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 32'd0};

        do_reset();
        check_reset_values("reset");
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);

        // Directed vectors: STEP 3 at div 0, STEP 0, halt vs commands
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].h);
            check($sformatf("vec%0d_tick", i),   bus.tick,       vecs[i].tick);
            check($sformatf("vec%0d_done", i),   bus.step_done,  vecs[i].done);
            check($sformatf("vec%0d_halted", i), bus.halted,     vecs[i].halted);
            check($sformatf("vec%0d_ready", i),  bus.cmd_ready,  vecs[i].ready);
            check($sformatf("vec%0d_steps", i),  bus.steps_left, vecs[i].steps);
            check($sformatf("vec%0d_div", i),    bus.divider_q,  vecs[i].div);
        end

        // Divider 4 in RUN: tick every 4th cycle, first one 4 edges after acceptance
        do_reset();
        drive(1'b1, OP_SET_DIV, 32'd4, 1'b0);
        drive(1'b1, OP_RUN, 32'd0, 1'b0);
        check("div4_running", bus.running, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            idle();
            check($sformatf("div4_tick_k%0d", k), bus.tick, (k % 4 == 0));
        end

        // Halt after the 4th tick of STEP 10 at divider 2
        do_reset();
        drive(1'b1, OP_SET_DIV, 32'd2, 1'b0);
        drive(1'b1, OP_STEP, 32'd10, 1'b0);
        ticks = 0;
        for (int k = 0; k < 30 && ticks < 4; k++) begin
            idle();
            if (bus.tick) ticks++;
        end
        check("step10_ticks_before_halt", ticks, 4);
        check("step10_steps_before_halt", bus.steps_left, 16'd6);
        drive(1'b0, OP_STOP, 32'd0, 1'b1);
        check("halt_halted", bus.halted, 1'b1);
        check("halt_tick", bus.tick, 1'b0);
        check("halt_done", bus.step_done, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            idle();
            seen = seen | bus.tick | bus.step_done;
        end
        check("halt_quiet_after", seen, 1'b0);
        check("halt_steps_kept", bus.steps_left, 16'd6);
        check("halt_still_halted", bus.halted, 1'b1);

        // Divider 8 -> 2 while counter is at 5
        do_reset();
        drive(1'b1, OP_SET_DIV, 32'd8, 1'b0);
        drive(1'b1, OP_RUN, 32'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            idle();
            check($sformatf("redivide_pre_k%0d", k), bus.tick, 1'b0);
        end
        drive(1'b1, OP_SET_DIV, 32'd2, 1'b0);
        check("redivide_load_tick", bus.tick, 1'b0);
        check("redivide_divider", bus.divider_q, 32'd2);
        for (int k = 7; k <= 12; k++) begin
            idle();
            check($sformatf("redivide_tick_k%0d", k), bus.tick, (k % 2 == 0));
        end

        // Asynchronous reset in the middle of a STEP, between edges
        do_reset();
        drive(1'b1, OP_SET_DIV, 32'd3, 1'b0);
        drive(1'b1, OP_STEP, 32'd5, 1'b0);
        repeat (4) idle();
        check("midstep_running", bus.running, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_tick", bus.tick, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            idle();
            seen = seen | bus.tick | bus.step_done;
        end
        check("after_reset_quiet", seen, 1'b0);
        check("after_reset_halted", bus.halted, 1'b1);

        // Random traffic against the behavioural model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        v;
            logic        h;
            logic [1:0]  op;
            logic [31:0] arg;
            v   = ($urandom_range(0, 3) == 0);
            op  = 2'($urandom_range(0, 3));
            arg = 32'($urandom_range(0, 6));
            h   = ($urandom_range(0, 23) == 0);
            drive(v, op, arg, h);
            model_edge(v, op, arg, h);
            check("rnd_tick",    bus.tick,       m_tick);
            check("rnd_done",    bus.step_done,  m_done);
            check("rnd_running", bus.running,    (m_mode != 0));
            check("rnd_halted",  bus.halted,     (m_mode == 0));
            check("rnd_ready",   bus.cmd_ready,  (m_mode != 2));
            check("rnd_divider", bus.divider_q,  m_div);
            check("rnd_steps",   bus.steps_left, 16'(m_left));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_clk_ctrl.md
DEBUG_CLK_CTRL -- requirements
Module: debug_clk_ctrl

Interface
REQ-001 Parameter COUNTER_BITS, default 32: width of the divider value and the divider counter.
REQ-002 Parameter STEP_BITS, default 16: width of the step counter.
REQ-003 clk  input  1: single system clock; all state updates occur on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 cmd_valid  input  1: command present.
REQ-006 cmd_ready  output  1: command accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  input  2: opcode; 00 STOP, 01 RUN, 10 STEP, 11 SET_DIV.
REQ-008 cmd_arg  input  COUNTER_BITS: STEP count (low STEP_BITS bits) or SET_DIV divider value.
REQ-009 halt_req  input  1: breakpoint or halt request, sampled as a level.
REQ-010 tick  output  1: registered one-cycle core-clock enable.
REQ-011 running  output  1: high in RUN or STEP.
REQ-012 halted  output  1: high in HALTED.
REQ-013 step_done  output  1: one-cycle pulse on natural completion of a STEP.
REQ-014 divider_q  output  COUNTER_BITS: current divider register.
REQ-015 steps_left  output  STEP_BITS: remaining step count.

Function
REQ-016 The FSM SHALL have three states: HALTED, RUN and STEP.
REQ-017 cmd_ready SHALL be high in HALTED and RUN, and low in STEP.
REQ-018 The effective divider SHALL be div_eff = max(divider_q, 1), so values 0 and 1 both give a tick every cycle.
REQ-019 The divider counter SHALL count 0..div_eff-1 and wrap to 0 while the FSM is in RUN or STEP, and SHALL be held at 0 in HALTED.
REQ-020 tick SHALL be set at an edge where the state is RUN or STEP, counter == div_eff-1 and halt_req is 0; otherwise tick SHALL be cleared.
REQ-021 For an accepted RUN or STEP at edge E0, the counter SHALL be 0 after E0 and the first tick SHALL be high in the cycle after edge E(div_eff).
REQ-022 RUN accepted in HALTED SHALL move the FSM to RUN and clear the counter.
REQ-023 RUN accepted in RUN SHALL be a no-op; the counter is not cleared.
REQ-024 STOP accepted in any state SHALL move the FSM to HALTED, clear the counter, and leave tick low from the next cycle.
REQ-025 STEP with a non-zero count accepted in HALTED SHALL load steps_left with the count, enter STEP and clear the counter.
REQ-026 STEP with a count of 0 SHALL leave the FSM in HALTED, and step_done SHALL pulse in the next cycle.
REQ-027 STEP accepted in RUN SHALL be treated as in HALTED: it loads steps_left, enters STEP and clears the counter.
REQ-028 In STEP, each tick SHALL decrement steps_left at the edge that sets tick.
REQ-029 When steps_left goes 1->0, the same edge SHALL set the state to HALTED and set step_done, so step_done is coincident with the last tick.
REQ-030 SET_DIV SHALL load divider_q from cmd_arg in any accepting state; in RUN it SHALL also clear the counter, and the next tick follows the new div_eff.
REQ-031 halt_req high at an edge in RUN or STEP SHALL force HALTED, suppress tick, leave step_done low and preserve steps_left.
REQ-032 halt_req SHALL take priority over a simultaneously accepted command, and that command is still consumed.
REQ-033 halt_req SHALL be ignored in HALTED, so a RUN accepted there takes effect.
REQ-034 Exactly tick_count = STEP count ticks SHALL be produced per uninterrupted STEP.

Reset
REQ-035 While reset_n is low, the block SHALL immediately hold: state HALTED, tick 0, running 0, halted 1, step_done 0, counter 0, steps_left 0, divider_q 1.
REQ-036 Reset asserted mid-RUN or mid-STEP SHALL abort with no further tick or step_done.
REQ-037 Operation SHALL resume only after the first clk edge following reset_n deassertion.

Structure
REQ-038 The state encoding, the opcode constants (OP_STOP, OP_RUN, OP_STEP, OP_SET_DIV) and the reset divider value SHALL live in a shared package, debug_pkg.
REQ-039 The divider counter and tick-compare logic SHALL be one sub-module, debug_tick_gen, with inputs enable, clear and div_eff, and output wrap.

Verification
REQ-040 Reset, then SET_DIV 4, then RUN: tick high for 1 cycle every 4 cycles, the first tick 4 cycles after RUN acceptance.
REQ-041 SET_DIV 0, then STEP 3: exactly 3 consecutive tick cycles, step_done coincident with the third, halted next cycle, steps_left 0, and cmd_ready low throughout STEP.
REQ-042 SET_DIV 2, STEP 10, then halt_req pulsed after the 4th tick: no further ticks, halted 1, step_done 0, steps_left 6.
REQ-043 In RUN with divider 8, SET_DIV 2 at counter 5: the next tick is 2 cycles later, followed by period 2.
REQ-044 STEP 0 -> one step_done pulse with no tick; STOP and halt_req together in RUN -> HALTED with the command consumed.
REQ-045 reset_n low mid-STEP, between clock edges -> outputs take reset values immediately, with no tick or step_done afterwards.
